// File: rtl/axi4_frame_writer.sv
// AXI4 write master: drains a FWFT pixel FIFO into an N-buffer DDR frame ring
// using INCR bursts, with a short final burst per frame and sof resynchronisation.
module axi4_frame_writer #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int BURST_LEN      = 16,
    parameter int NUM_FRAMES     = 3,
    parameter int FRAME_BYTES    = 614400,
    parameter int FIFO_CNT_WIDTH = 11
) (
    input  logic                          clk_100Mhz,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          sof,
    input  logic [AXI_ADDR_WIDTH-1:0]     FRAME_BASE_ADDR,
    input  logic [AXI_ADDR_WIDTH-1:0]     FRAME_STRIDE,
    input  logic [AXI_DATA_WIDTH-1:0]     fifo_dout,
    input  logic [FIFO_CNT_WIDTH-1:0]     fifo_count,
    output logic                          fifo_rd_en,
    output logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [7:0]                    AWLEN,
    output logic [2:0]                    AWSIZE,
    output logic [1:0]                    AWBURST,
    output logic [3:0]                    AWCACHE,
    output logic [2:0]                    AWPROT,
    output logic [AXI_DATA_WIDTH-1:0]     WDATA,
    output logic                          WVALID,
    input  logic                          WREADY,
    output logic                          WLAST,
    output logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                          BVALID,
    output logic                          BREADY,
    input  logic [1:0]                    BRESP,
    output logic                          frame_wr_done,
    output logic [1:0]                    frame_idx,
    output logic [1:0]                    wr_frame_idx,
    output logic                          bresp_err,
    output logic [1:0]                    state,
    output logic [AXI_ADDR_WIDTH-1:0]     ADDR_OFFSET
);

    localparam int BPB       = AXI_DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BPB);
    localparam logic [AXI_ADDR_WIDTH-1:0] FRAME_BYTES_A = AXI_ADDR_WIDTH'(FRAME_BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_LEN_A   = AXI_ADDR_WIDTH'(BURST_LEN);
    localparam logic [1:0]                LAST_FRAME    = 2'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]                awlen_q, awlen_d;
    logic [7:0]                beat_q, beat_d;
    logic [1:0]                wr_idx_q, wr_idx_d;
    logic [1:0]                frame_idx_q, frame_idx_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      sof_pend_q, sof_pend_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      wlast_q, wlast_d;
    logic                      bready_q, bready_d;

    logic [AXI_ADDR_WIDTH-1:0] rem_beats;
    logic [AXI_ADDR_WIDTH-1:0] beats;
    logic [AXI_ADDR_WIDTH-1:0] burst_bytes;
    logic [AXI_ADDR_WIDTH-1:0] next_off;
    logic [AXI_ADDR_WIDTH-1:0] frame_base;
    logic                      fifo_ok;
    logic                      w_hs;

    // The last burst of a frame shrinks to whatever is left of it.
    assign rem_beats   = (FRAME_BYTES_A - offset_q) >> SIZE_LOG2;
    assign beats       = (rem_beats < BURST_LEN_A) ? rem_beats : BURST_LEN_A;
    assign fifo_ok     = AXI_ADDR_WIDTH'(fifo_count) >= beats;
    assign burst_bytes = (AXI_ADDR_WIDTH'(awlen_q) + AXI_ADDR_WIDTH'(1)) << SIZE_LOG2;
    assign next_off    = offset_q + burst_bytes;
    assign frame_base  = FRAME_BASE_ADDR + AXI_ADDR_WIDTH'(wr_idx_q) * FRAME_STRIDE;
    assign w_hs        = wvalid_q & WREADY;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        offset_d    = offset_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        beat_d      = beat_q;
        wr_idx_d    = wr_idx_q;
        frame_idx_d = frame_idx_q;
        done_d      = 1'b0;
        err_d       = err_q;
        sof_pend_d  = sof_pend_q | (sof & (state_q != S_IDLE));
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        bready_d    = bready_q;

        case (state_q)
            S_IDLE: begin
                if (sof) begin
                    offset_d   = '0;
                    sof_pend_d = 1'b0;
                end else if (enable && fifo_ok && !sof_pend_q) begin
                    awlen_d   = 8'(beats - AXI_ADDR_WIDTH'(1));
                    awaddr_d  = frame_base + offset_q;
                    awvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (awlen_q == 8'd0);
                    beat_d    = 8'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wlast_d = (beat_q + 8'd1 == awlen_q);
                    end
                end
            end
            S_RESP: begin
                if (BVALID) begin
                    bready_d   = 1'b0;
                    sof_pend_d = 1'b0;
                    state_d    = S_IDLE;
                    if (BRESP inside {2'b10, 2'b11}) begin
                        err_d = 1'b1;
                    end
                    // Frame completion takes priority over a pending resync.
                    if (next_off == FRAME_BYTES_A) begin
                        offset_d    = '0;
                        frame_idx_d = wr_idx_q;
                        wr_idx_d    = (wr_idx_q == LAST_FRAME) ? 2'd0 : wr_idx_q + 2'd1;
                        done_d      = 1'b1;
                    end else if (sof_pend_q || sof) begin
                        offset_d = '0;
                    end else begin
                        offset_d = next_off;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            beat_q      <= '0;
            wr_idx_q    <= '0;
            frame_idx_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sof_pend_q  <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q     <= state_d;
            offset_q    <= offset_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            beat_q      <= beat_d;
            wr_idx_q    <= wr_idx_d;
            frame_idx_q <= frame_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sof_pend_q  <= sof_pend_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
        end
    end

    assign AWADDR        = awaddr_q;
    assign AWVALID       = awvalid_q;
    assign AWLEN         = awlen_q;
    assign AWSIZE        = 3'(SIZE_LOG2);
    assign AWBURST       = 2'b01;
    assign AWCACHE       = 4'b0011;
    assign AWPROT        = 3'b000;
    assign WDATA         = fifo_dout;
    assign WVALID        = wvalid_q;
    assign WLAST         = wlast_q;
    assign WSTRB         = '1;
    assign BREADY        = bready_q;
    assign fifo_rd_en    = w_hs;
    assign frame_wr_done = done_q;
    assign frame_idx     = frame_idx_q;
    assign wr_frame_idx  = wr_idx_q;
    assign bresp_err     = err_q;
    assign state         = state_q;
    assign ADDR_OFFSET   = offset_q;

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Self-checking bench for axi4_frame_writer: random-ready AXI slave, FWFT FIFO
// model and a frame/burst reference computed from offsets and buffer indices.
module tb_axi4_frame_writer;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int BL    = 16;
    localparam int NF    = 3;
    localparam int FB    = 1000;
    localparam int CW    = 11;
    localparam int BPB   = DW / 8;
    localparam int MEM_N = 4096;
    localparam logic [AW-1:0] BASE   = 32'h1000_0000;
    localparam logic [AW-1:0] STRIDE = 32'h0010_0000;

    logic          clk, rst_n, enable, sof;
    logic [AW-1:0] frame_base_addr, frame_stride;
    logic [DW-1:0] fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_rd_en;
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [7:0]    awlen;
    logic [2:0]    awsize, awprot;
    logic [1:0]    awburst;
    logic [3:0]    awcache;
    logic [DW-1:0] wdata;
    logic          wvalid, wready, wlast;
    logic [7:0]    wstrb;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          frame_wr_done, bresp_err;
    logic [1:0]    frame_idx, wr_frame_idx, state;
    logic [AW-1:0] addr_offset;

    axi4_frame_writer #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BURST_LEN(BL),
        .NUM_FRAMES(NF), .FRAME_BYTES(FB), .FIFO_CNT_WIDTH(CW)
    ) dut (
        .clk_100Mhz(clk), .rst_n(rst_n), .enable(enable), .sof(sof),
        .FRAME_BASE_ADDR(frame_base_addr), .FRAME_STRIDE(frame_stride),
        .fifo_dout(fifo_dout), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
        .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready), .AWLEN(awlen),
        .AWSIZE(awsize), .AWBURST(awburst), .AWCACHE(awcache), .AWPROT(awprot),
        .WDATA(wdata), .WVALID(wvalid), .WREADY(wready), .WLAST(wlast), .WSTRB(wstrb),
        .BVALID(bvalid), .BREADY(bready), .BRESP(bresp),
        .frame_wr_done(frame_wr_done), .frame_idx(frame_idx), .wr_frame_idx(wr_frame_idx),
        .bresp_err(bresp_err), .state(state), .ADDR_OFFSET(addr_offset)
    );

    int total = 0;
    int bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream FIFO: a pre-filled random word stream, advanced by the DUT's pops.
    logic [DW-1:0] fifo_mem [MEM_N];
    int rd_ptr   = 0;
    int base_ptr = 0;
    assign fifo_dout = fifo_mem[rd_ptr % MEM_N];

    logic [AW-1:0] aw_addr_q [$];
    int            aw_len_q  [$];
    int            aw_cyc_q  [$];
    logic [DW-1:0] w_data_q  [$];
    bit            w_last_q  [$];
    int            w_cyc_q   [$];
    int            done_fidx [$];
    int            done_widx [$];
    int rd_cnt = 0, b_cnt = 0, viol = 0, cyc = 0;
    bit rnd_ready = 1'b0;
    int b_delay   = 0;
    int err_burst = -1;

    // Slave/monitor: samples on the falling edge, drives responses just after the rising edge.
    initial begin
        bit            p_wstall, p_awstall, pend, b_hs, last_hs, pop;
        logic [DW-1:0] p_wdata;
        logic [AW-1:0] p_awaddr;
        logic [7:0]    p_awlen;
        int            bc;
        p_wstall = 0; p_awstall = 0; pend = 0; bc = 0;
        p_wdata = '0; p_awaddr = '0; p_awlen = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (p_wstall && !(wvalid && wdata === p_wdata)) viol++;
                if (p_awstall && !(awvalid && awaddr === p_awaddr && awlen === p_awlen)) viol++;
                if (fifo_rd_en !== (wvalid && wready)) viol++;
                if (bready && state !== 2'd3) viol++;
                if (wvalid && state !== 2'd2) viol++;
            end
            p_wstall  = rst_n && wvalid && !wready;
            p_awstall = rst_n && awvalid && !awready;
            p_wdata   = wdata;
            p_awaddr  = awaddr;
            p_awlen   = awlen;
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(int'(awlen));
                aw_cyc_q.push_back(cyc);
            end
            if (wvalid && wready) begin
                w_data_q.push_back(wdata);
                w_last_q.push_back(wlast);
                w_cyc_q.push_back(cyc);
            end
            last_hs = wvalid && wready && wlast;
            pop     = fifo_rd_en;
            if (pop) rd_cnt++;
            b_hs = bvalid && bready;
            if (b_hs) b_cnt++;
            if (frame_wr_done) begin
                done_fidx.push_back(int'(frame_idx));
                done_widx.push_back(int'(wr_frame_idx));
            end
            @(posedge clk);
            #1;
            if (pop) rd_ptr++;
            awready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rst_n) begin
                pend   = 0;
                bvalid = 1'b0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (last_hs) begin
                    pend = 1;
                    bc   = b_delay;
                end
                if (pend && !bvalid) begin
                    if (bc == 0) begin
                        bvalid = 1'b1;
                        bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
                        pend   = 0;
                    end else begin
                        bc--;
                    end
                end
            end
        end
    end

    function automatic int exp_len(input int off);
        int r;
        r = (FB - off) / BPB;
        return (r < BL) ? r : BL;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        aw_addr_q.delete(); aw_len_q.delete(); aw_cyc_q.delete();
        w_data_q.delete(); w_last_q.delete(); w_cyc_q.delete();
        done_fidx.delete(); done_widx.delete();
        rd_cnt = 0; b_cnt = 0; viol = 0;
        base_ptr = rd_ptr;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        sof    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (state == 2'd0 && !awvalid) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_frames(input int n, input int max_cyc, output bit ok);
        bit idle_ok;
        ok = 0;
        enable = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (done_fidx.size() >= n) begin
                ok = 1;
                break;
            end
        end
        enable = 1'b0;
        wait_idle(200, idle_ok);
        ok = ok && idle_ok;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; sof = 1'b0;
        frame_base_addr = BASE; frame_stride = STRIDE; fifo_count = 11'd200;
        repeat (3) tick();
        total++;
        if ({awvalid, wvalid, wlast, bready, fifo_rd_en, frame_wr_done, bresp_err} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000000",
                {awvalid, wvalid, wlast, bready, fifo_rd_en, frame_wr_done, bresp_err});
        end
        total++;
        if (state !== 2'd0 || addr_offset !== '0 || awaddr !== '0 || awlen !== 8'd0) begin
            bad++; $display("FAIL reset_regs: state=%0d off=%h awaddr=%h awlen=%0d want all 0",
                state, addr_offset, awaddr, awlen);
        end
        total++;
        if (frame_idx !== 2'd0 || wr_frame_idx !== 2'd0) begin
            bad++; $display("FAIL reset_idx: frame_idx=%0d wr_frame_idx=%0d want 0 0", frame_idx, wr_frame_idx);
        end
        total++;
        if ({awsize, awburst, awcache, awprot, wstrb} !== {3'd3, 2'b01, 4'b0011, 3'b000, 8'hff}) begin
            bad++; $display("FAIL axi_consts: got %h want %h",
                {awsize, awburst, awcache, awprot, wstrb}, {3'd3, 2'b01, 4'b0011, 3'b000, 8'hff});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_gating();
        bit ok;
        do_reset();
        fifo_count = 11'd15;
        enable = 1'b1;
        repeat (20) tick();
        total++;
        if (awvalid !== 1'b0 || state !== 2'd0) begin
            bad++; $display("FAIL gate_fifo: awvalid=%b state=%0d want 0 0", awvalid, state);
        end
        enable = 1'b0;
        fifo_count = 11'd200;
        repeat (5) tick();
        total++;
        if (awvalid !== 1'b0 || state !== 2'd0) begin
            bad++; $display("FAIL gate_enable: awvalid=%b state=%0d want 0 0", awvalid, state);
        end
        fifo_count = 11'd16;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        total++;
        if (awvalid !== 1'b1 || awaddr !== BASE || awlen !== 8'd15) begin
            bad++; $display("FAIL aw_rise: awvalid=%b awaddr=%h awlen=%0d want 1 %h 15", awvalid, awaddr, awlen, BASE);
        end
        wait_idle(200, ok);
        total++;
        if (!ok || addr_offset !== 32'd128) begin
            bad++; $display("FAIL gate_burst_end: idle=%0d off=%0d want 1 128", ok, addr_offset);
        end
        fifo_count = 11'd200;
    endtask

    task automatic test_full_frames();
        bit ok;
        int m_off, m_buf, wi, len;
        logic [AW-1:0] ea;
        rnd_ready = 1'b0; b_delay = 0; err_burst = -1;
        do_reset();
        run_frames(3, 3000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_timeout: got %0d frames want 3", done_fidx.size()); end
        total++;
        if (aw_addr_q.size() != 24 || w_data_q.size() != 375 || rd_cnt != 375) begin
            bad++; $display("FAIL full_counts: aw=%0d w=%0d rd=%0d want 24 375 375",
                aw_addr_q.size(), w_data_q.size(), rd_cnt);
        end
        m_off = 0; m_buf = 0; wi = 0;
        for (int b = 0; b < aw_addr_q.size(); b++) begin
            len = exp_len(m_off);
            ea  = BASE + AW'(m_buf) * STRIDE + AW'(m_off);
            total++;
            if (aw_addr_q[b] !== ea || aw_len_q[b] != len - 1) begin
                bad++; $display("FAIL full_aw[%0d]: got %h/%0d want %h/%0d", b, aw_addr_q[b], aw_len_q[b], ea, len - 1);
            end
            if (wi < w_cyc_q.size()) begin
                total++;
                if (w_cyc_q[wi] != aw_cyc_q[b] + 1) begin
                    bad++; $display("FAIL full_first_w[%0d]: got cycle %0d want %0d", b, w_cyc_q[wi], aw_cyc_q[b] + 1);
                end
            end
            for (int i = 0; i < len && wi + i < w_data_q.size(); i++) begin
                total++;
                if (w_data_q[wi + i] !== fifo_mem[(base_ptr + wi + i) % MEM_N] || w_last_q[wi + i] != (i == len - 1)) begin
                    bad++; $display("FAIL full_w[%0d.%0d]: got %h last=%0d want %h last=%0d", b, i,
                        w_data_q[wi + i], w_last_q[wi + i], fifo_mem[(base_ptr + wi + i) % MEM_N], i == len - 1);
                end
            end
            wi += len;
            m_off += len * BPB;
            if (m_off == FB) begin m_off = 0; m_buf = (m_buf + 1) % NF; end
        end
        if (aw_addr_q.size() == 24) begin
            total++;
            if (aw_len_q[7] != 12 || aw_addr_q[8] !== 32'h1010_0000 || aw_addr_q[16] !== 32'h1020_0000) begin
                bad++; $display("FAIL full_bases: len7=%0d a8=%h a16=%h want 12 10100000 10200000",
                    aw_len_q[7], aw_addr_q[8], aw_addr_q[16]);
            end
        end
        total++;
        if (done_widx.size() != 3 || done_widx[0] != 1 || done_widx[1] != 2 || done_widx[2] != 0
            || done_fidx[0] != 0 || done_fidx[1] != 1 || done_fidx[2] != 2) begin
            bad++; $display("FAIL full_ring: n=%0d widx=%p fidx=%p want 3 '{1,2,0} '{0,1,2}",
                done_widx.size(), done_widx, done_fidx);
        end
        total++;
        if (addr_offset !== '0 || wr_frame_idx !== 2'd0 || frame_idx !== 2'd2 || viol != 0) begin
            bad++; $display("FAIL full_end: off=%0d widx=%0d fidx=%0d viol=%0d want 0 0 2 0",
                addr_offset, wr_frame_idx, frame_idx, viol);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int m_off, wi, len;
        rnd_ready = 1'b1; b_delay = 5; err_burst = -1;
        do_reset();
        run_frames(1, 8000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout: got %0d frames want 1", done_fidx.size()); end
        total++;
        if (aw_addr_q.size() != 8 || w_data_q.size() != 125 || rd_cnt != 125 || viol != 0) begin
            bad++; $display("FAIL bp_counts: aw=%0d w=%0d rd=%0d viol=%0d want 8 125 125 0",
                aw_addr_q.size(), w_data_q.size(), rd_cnt, viol);
        end
        m_off = 0; wi = 0;
        for (int b = 0; b < aw_addr_q.size(); b++) begin
            len = exp_len(m_off);
            total++;
            if (aw_addr_q[b] !== BASE + AW'(m_off) || aw_len_q[b] != len - 1) begin
                bad++; $display("FAIL bp_aw[%0d]: got %h/%0d want %h/%0d", b, aw_addr_q[b], aw_len_q[b],
                    BASE + AW'(m_off), len - 1);
            end
            for (int i = 0; i < len && wi + i < w_data_q.size(); i++) begin
                total++;
                if (w_data_q[wi + i] !== fifo_mem[(base_ptr + wi + i) % MEM_N] || w_last_q[wi + i] != (i == len - 1)) begin
                    bad++; $display("FAIL bp_w[%0d.%0d]: got %h last=%0d want %h last=%0d", b, i,
                        w_data_q[wi + i], w_last_q[wi + i], fifo_mem[(base_ptr + wi + i) % MEM_N], i == len - 1);
                end
            end
            wi += len;
            m_off = (m_off + len * BPB) % FB;
        end
        total++;
        if (done_fidx.size() != 1 || done_fidx[0] != 0 || done_widx[0] != 1) begin
            bad++; $display("FAIL bp_done: n=%0d fidx=%p widx=%p want 1 '{0} '{1}", done_fidx.size(), done_fidx, done_widx);
        end
        rnd_ready = 1'b0;
        b_delay = 0;
    endtask

    task automatic test_sof();
        bit ok;
        int n;
        rnd_ready = 1'b0; b_delay = 0; err_burst = -1;
        do_reset();
        enable = 1'b1;
        n = 0;
        while (aw_addr_q.size() < 3 && n < 500) begin tick(); n++; end
        tick();
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL sof_in_data: state=%0d want 2", state); end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        n = 0;
        while (aw_addr_q.size() < 4 && n < 500) begin tick(); n++; end
        enable = 1'b0;
        total++;
        if (aw_addr_q.size() != 4) begin
            bad++; $display("FAIL sof_timeout: got %0d bursts want 4", aw_addr_q.size());
        end else if (aw_addr_q[2] !== BASE + 32'h100 || aw_addr_q[3] !== BASE) begin
            bad++; $display("FAIL sof_resync_addr: got %h %h want %h %h", aw_addr_q[2], aw_addr_q[3], BASE + 32'h100, BASE);
        end
        wait_idle(200, ok);
        total++;
        if (!ok || done_fidx.size() != 0 || addr_offset !== 32'd128 || wr_frame_idx !== 2'd0) begin
            bad++; $display("FAIL sof_after: idle=%0d done=%0d off=%0d widx=%0d want 1 0 128 0",
                ok, done_fidx.size(), addr_offset, wr_frame_idx);
        end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        total++;
        if (addr_offset !== '0 || wr_frame_idx !== 2'd0 || state !== 2'd0) begin
            bad++; $display("FAIL sof_idle: off=%0d widx=%0d state=%0d want 0 0 0", addr_offset, wr_frame_idx, state);
        end
    endtask

    task automatic test_bresp_error();
        bit ok;
        rnd_ready = 1'b0; b_delay = 2; err_burst = 2;
        do_reset();
        total++;
        if (bresp_err !== 1'b0) begin bad++; $display("FAIL err_initial: got %b want 0", bresp_err); end
        run_frames(2, 3000, ok);
        total++;
        if (!ok || bresp_err !== 1'b1) begin
            bad++; $display("FAIL err_set: done=%0d bresp_err=%b want 1 1", ok, bresp_err);
        end
        total++;
        if (done_widx.size() != 2 || done_widx[0] != 1 || done_widx[1] != 2 || done_fidx[1] != 1 || aw_addr_q.size() != 16) begin
            bad++; $display("FAIL err_ring: n=%0d widx=%p fidx=%p aw=%0d want 2 '{1,2} fidx[1]=1 16",
                done_widx.size(), done_widx, done_fidx, aw_addr_q.size());
        end
        repeat (10) tick();
        total++;
        if (bresp_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bresp_err); end
        err_burst = -1;
        b_delay = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        enable = 1'b1;
        n = 0;
        while (w_data_q.size() < 5 && n < 500) begin tick(); n++; end
        total++;
        if (state !== 2'd2 || wr_frame_idx !== 2'd2 || bresp_err !== 1'b1) begin
            bad++; $display("FAIL rst_pre: state=%0d widx=%0d err=%b want 2 2 1", state, wr_frame_idx, bresp_err);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({awvalid, wvalid, wlast, bready, fifo_rd_en, frame_wr_done, bresp_err} !== 7'b0) begin
            bad++; $display("FAIL rst_mid_ctrl: got %b want 0000000",
                {awvalid, wvalid, wlast, bready, fifo_rd_en, frame_wr_done, bresp_err});
        end
        total++;
        if (state !== 2'd0 || addr_offset !== '0 || awaddr !== '0 || awlen !== 8'd0
            || frame_idx !== 2'd0 || wr_frame_idx !== 2'd0) begin
            bad++; $display("FAIL rst_mid_regs: state=%0d off=%h awaddr=%h awlen=%0d fidx=%0d widx=%0d want all 0",
                state, addr_offset, awaddr, awlen, frame_idx, wr_frame_idx);
        end
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sof = 1'b0;
        frame_base_addr = BASE; frame_stride = STRIDE; fifo_count = 11'd200;
        for (int i = 0; i < MEM_N; i++) fifo_mem[i] = {$urandom, $urandom};
        test_reset();
        test_idle_gating();
        test_full_frames();
        test_backpressure();
        test_sof();
        test_bresp_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
